spi_reg_bridge: RTL and testbench

- SPI slave (mode 0, MSB first) that lets the nRF MCU read and write the 16x8 register memory.
- Sits directly upstream of the memory block. It drives the memory's address, write-data and write-strobe, and consumes its registered read data (1-cycle read latency).
- All SPI pins are oversampled in the i_Clk domain. No second clock domain.

---
 rtl/spi_reg_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging an external MCU onto a small register memory.
// All SPI pins are oversampled in the i_Clk domain (i_Clk >= 16x SCLK).
//
// Frame: byte 0 = command {rw, 3'b000, start_addr}, bytes 1..N = data with the
// address auto-incrementing (wrapping) after each byte.
//
// Ports:
//   i_Clk, i_Rst_n        system clock, async active-low reset
//   i_SPI_SCLK/MOSI/CS_n  raw SPI inputs from the MCU
//   o_SPI_MISO            serial read data, o_SPI_MISO_En high while CS active
//   o_Mem_Addr/Data/Write memory address, write data, 1-cycle write strobe
//   i_Mem_Data            registered memory read data (1-cycle latency)
//   o_Err                 1-cycle pulse on an illegal command byte
module spi_reg_bridge #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_SPI_SCLK,
  input  logic              i_SPI_MOSI,
  input  logic              i_SPI_CS_n,
  output logic              o_SPI_MISO,
  output logic              o_SPI_MISO_En,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_Data,
  output logic              o_Mem_Write,
  input  logic [DATA_W-1:0] i_Mem_Data,
  output logic              o_Err
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdFetch,
    StRdData,
    StDiscard
  } state_e;

  // Synchronisers and edge detection
  logic [1:0] sclk_sync_q;
  logic       sclk_prev_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic       cs_prev_q;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // CS synchroniser resets to the inactive level so reset release never fakes a frame start.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sclk_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], i_SPI_SCLK};
      sclk_prev_q <= sclk_sync_q[1];
      mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
      cs_sync_q   <= {cs_sync_q[0], i_SPI_CS_n};
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // State and datapath registers
  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q;
  logic [1:0]          fetch_cnt_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   tx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                err_q;
  logic                miso_en_q;

  logic [DATA_W-1:0]   rx_byte;
  logic                byte_done;
  logic                load_addr, inc_addr_rd, do_write, load_tx, err_d;

  assign rx_byte   = {rx_q[DATA_W-2:0], mosi_s};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7) & (state_q != StIdle);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr   = 1'b0;
    inc_addr_rd = 1'b0;
    do_write    = 1'b0;
    load_tx     = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StCmd;
      end
      StCmd: begin
        if (byte_done) begin
          if (rx_byte[6:4] != 3'b000) begin
            err_d   = 1'b1;
            state_d = StDiscard;
          end else begin
            load_addr = 1'b1;
            state_d   = rx_byte[DATA_W-1] ? StRdFetch : StWrData;
          end
        end
      end
      StWrData: begin
        if (byte_done) do_write = 1'b1;
      end
      StRdFetch: begin
        // Third cycle: registered memory output is stable for the loaded address.
        if (fetch_cnt_q == 2'd2) begin
          load_tx = 1'b1;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (byte_done) begin
          inc_addr_rd = 1'b1;
          state_d     = StRdFetch;
        end
      end
      StDiscard: begin
        state_d = StDiscard;
      end
      default: state_d = StIdle;
    endcase
    // A byte completing in the same cycle as CS rising is still processed above.
    if (cs_rise && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bit_cnt_q   <= 3'd0;
      fetch_cnt_q <= 2'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      miso_en_q   <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        bit_cnt_q <= 3'd0;
        rx_q      <= '0;
      end else if (sclk_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        rx_q      <= rx_byte;
      end

      fetch_cnt_q <= (state_q == StRdFetch) ? fetch_cnt_q + 2'd1 : 2'd0;

      // No shift on the falling edge that closes a byte (bit_cnt wrapped to 0):
      // that edge must leave the freshly fetched MSB on the line.
      if (state_q == StIdle) begin
        tx_q <= '0;
      end else if (load_tx) begin
        tx_q <= i_Mem_Data;
      end else if ((state_q == StRdData) && sclk_fall && (bit_cnt_q != 3'd0)) begin
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end

      if (load_addr) begin
        addr_q <= rx_byte[ADDR_W-1:0];
      end else if (inc_addr_rd || write_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (do_write) wdata_q <= rx_byte;
      write_q   <= do_write;
      err_q     <= err_d;
      miso_en_q <= ~cs_s;
    end
  end

  assign o_SPI_MISO    = (state_q == StRdData) & tx_q[DATA_W-1];
  assign o_SPI_MISO_En = miso_en_q;
  assign o_Mem_Addr    = addr_q;
  assign o_Mem_Data    = wdata_q;
  assign o_Mem_Write   = write_q;
  assign o_Err         = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
`timescale 1ns/1ps
module tb_spi_reg_bridge;

  localparam int Half = 8;  // SCLK half period in i_Clk cycles (16x ratio)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso, miso_en, mem_write, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  spi_reg_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_SPI_SCLK   (sclk),
    .i_SPI_MOSI   (mosi),
    .i_SPI_CS_n   (cs_n),
    .o_SPI_MISO   (miso),
    .o_SPI_MISO_En(miso_en),
    .o_Mem_Addr   (mem_addr),
    .o_Mem_Data   (mem_wdata),
    .o_Mem_Write  (mem_write),
    .i_Mem_Data   (mem_rdata),
    .o_Err        (err)
  );

  always #5 clk = ~clk;

  // Register memory model with a backdoor preload port
  logic [7:0] mem [16];
  logic       pre_en = 1'b0;
  logic [3:0] pre_addr = 4'd0;
  logic [7:0] pre_data = 8'd0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Monitors: counts are monotonic, tests work on deltas
  int         wr_count = 0;
  int         err_count = 0;
  int         miso_hi_count = 0;
  logic [3:0] wr_addr_log [$];
  logic [7:0] wr_data_log [$];

  always @(posedge clk) begin
    if (mem_write) begin
      wr_count++;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    if (err) err_count++;
    if (miso) miso_hi_count++;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic half_period();
    repeat (Half) @(negedge clk);
  endtask

  // Mode 0 master: drive MOSI while SCLK low, sample MISO just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      half_period();
      rx[7-i] = miso;
      sclk = 1'b1;
      half_period();
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    half_period();
  endtask

  task automatic cs_high();
    half_period();
    cs_n = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " addr"}, 32'(mem_addr), 32'h0);
    check_eq({tag, " wdata"}, 32'(mem_wdata), 32'h0);
    check_eq({tag, " write"}, 32'(mem_write), 32'h0);
    check_eq({tag, " err"}, 32'(err), 32'h0);
    check_eq({tag, " miso"}, 32'(miso), 32'h0);
    check_eq({tag, " miso_en"}, 32'(miso_en), 32'h0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rx2;
    int wr0, err0, hi0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write: cmd 0x03, data 0xA5
    wr0 = wr_count; err0 = err_count;
    cs_low();
    check_eq("wr1 miso_en active", 32'(miso_en), 32'h1);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hA5, 8, rx);
    cs_high();
    check_eq("wr1 strobes", 32'(wr_count - wr0), 32'd1);
    check_eq("wr1 addr", 32'(wr_addr_log[wr0]), 32'h3);
    check_eq("wr1 data", 32'(wr_data_log[wr0]), 32'hA5);
    check_eq("wr1 no err", 32'(err_count - err0), 32'd0);
    check_eq("wr1 addr post-inc", 32'(mem_addr), 32'h4);
    check_eq("wr1 miso_en idle", 32'(miso_en), 32'h0);

    // Burst write with wrap: cmd 0x0E, 0x11 0x22 0x33 -> 14, 15, 0
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h0E, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    cs_high();
    check_eq("burst strobes", 32'(wr_count - wr0), 32'd3);
    check_eq("burst addr0", 32'(wr_addr_log[wr0]), 32'hE);
    check_eq("burst data0", 32'(wr_data_log[wr0]), 32'h11);
    check_eq("burst addr1", 32'(wr_addr_log[wr0+1]), 32'hF);
    check_eq("burst data1", 32'(wr_data_log[wr0+1]), 32'h22);
    check_eq("burst addr2 wrap", 32'(wr_addr_log[wr0+2]), 32'h0);
    check_eq("burst data2", 32'(wr_data_log[wr0+2]), 32'h33);
    check_eq("burst addr post", 32'(mem_addr), 32'h1);

    // Single read: mem[5] = 0x5C, cmd 0x85 + one dummy
    preload(4'd5, 8'h5C);
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_high();
    check_eq("rd1 data", 32'(rx), 32'h5C);
    check_eq("rd1 no write", 32'(wr_count - wr0), 32'd0);
    check_eq("rd1 addr post", 32'(mem_addr), 32'h6);

    // Burst read with wrap: mem[15] = 0xF0, mem[0] = 0x0F, cmd 0x8F + two dummies
    preload(4'd15, 8'hF0);
    preload(4'd0, 8'h0F);
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h8F, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx2);
    cs_high();
    check_eq("rdb byte0", 32'(rx), 32'hF0);
    check_eq("rdb byte1", 32'(rx2), 32'h0F);
    check_eq("rdb no write", 32'(wr_count - wr0), 32'd0);
    check_eq("rdb addr post", 32'(mem_addr), 32'h1);

    // Abort: cmd 0x02, 4 data bits, CS high
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hB0, 4, rx);
    cs_high();
    check_eq("abort no write", 32'(wr_count - wr0), 32'd0);
    check_eq("abort addr hold", 32'(mem_addr), 32'h2);
    check_eq("abort miso_en", 32'(miso_en), 32'h0);
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_high();
    check_eq("post-abort strobes", 32'(wr_count - wr0), 32'd1);
    check_eq("post-abort addr", 32'(wr_addr_log[wr0]), 32'h2);
    check_eq("post-abort data", 32'(wr_data_log[wr0]), 32'h77);

    // Illegal command 0x40, then 0xFF
    wr0 = wr_count; err0 = err_count; hi0 = miso_hi_count;
    cs_low();
    spi_bits(8'h40, 8, rx);
    spi_bits(8'hFF, 8, rx);
    cs_high();
    check_eq("illegal err cycles", 32'(err_count - err0), 32'd1);
    check_eq("illegal no write", 32'(wr_count - wr0), 32'd0);
    check_eq("illegal miso low", 32'(miso_hi_count - hi0), 32'd0);

    // Async reset in the middle of a write data byte
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'hC3, 4, rx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midreset no write", 32'(wr_count - wr0), 32'd0);

    // Fresh frames after reset release: write then read back
    wr0 = wr_count;
    cs_low();
    spi_bits(8'h09, 8, rx);
    spi_bits(8'h3C, 8, rx);
    cs_high();
    check_eq("fresh strobes", 32'(wr_count - wr0), 32'd1);
    check_eq("fresh addr", 32'(wr_addr_log[wr0]), 32'h9);
    check_eq("fresh data", 32'(wr_data_log[wr0]), 32'h3C);
    cs_low();
    spi_bits(8'h89, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_high();
    check_eq("fresh readback", 32'(rx), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
